// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: round-robin between ALU (A) and
// multi-cycle unit (B), with a pending-destination scoreboard for B.
module regfile_wb_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NREG    = 32,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [ADDR_W-1:0] a_waddr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic [ADDR_W-1:0] b_waddr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  input  logic              iss_valid_i,
  input  logic [ADDR_W-1:0] iss_waddr_i,
  output logic              iss_stall_o,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  input  logic              dst_en_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  output logic              rd_stall_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_waddr_o,
  output logic [DATA_W-1:0] wb_wdata_o
);

  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_e;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  side_e             last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREG-1:0]   pend_q, pend_d;
  logic              wb_we_q, wb_we_d;
  logic [ADDR_W-1:0] wb_waddr_q, wb_waddr_d;
  logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;

  logic ga, gb;
  logic iss_fire;
  logic cnt_full;
  logic cnt_dec;

  function automatic logic pend_at(
    input logic [NREG-1:0]   vec,
    input logic [ADDR_W-1:0] addr
  );
    return (addr != '0) && vec[addr];
  endfunction

  // Round-robin grant; the side that did not win last time gets priority.
  always_comb begin
    ga = a_valid_i & (~b_valid_i | (last_q == SIDE_B));
    gb = b_valid_i & (~a_valid_i | (last_q == SIDE_A));
  end

  assign a_ready_o = ga;
  assign b_ready_o = gb;

  // Issue gating: outstanding limit and WAW against a pending destination.
  always_comb begin
    cnt_full    = (cnt_q == MAX_C);
    iss_stall_o = cnt_full | pend_at(pend_q, iss_waddr_i);
    iss_fire    = iss_valid_i & ~iss_stall_o;
    cnt_dec     = gb & (cnt_q != '0);
  end

  // Decode-side RAW/WAW hazard against pending B destinations.
  always_comb begin
    rd_stall_o = (re1_i & pend_at(pend_q, raddr1_i))
               | (re2_i & pend_at(pend_q, raddr2_i))
               | (dst_en_i & pend_at(pend_q, dst_addr_i));
  end

  // Next-state for arbitration history, counter and scoreboard.
  always_comb begin
    last_d = last_q;
    if (ga) begin
      last_d = SIDE_A;
    end else if (gb) begin
      last_d = SIDE_B;
    end

    cnt_d = cnt_q;
    if (iss_fire && !cnt_dec) begin
      cnt_d = cnt_q + ONE_C;
    end else if (!iss_fire && cnt_dec) begin
      cnt_d = cnt_q - ONE_C;
    end

    pend_d = pend_q;
    if (gb) begin
      pend_d[b_waddr_i] = 1'b0;
    end
    if (iss_fire && (iss_waddr_i != '0)) begin
      pend_d[iss_waddr_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // Write stage next-state: winner's addr/data, hold when idle.
  always_comb begin
    wb_we_d    = 1'b0;
    wb_waddr_d = wb_waddr_q;
    wb_wdata_d = wb_wdata_q;
    unique case (1'b1)
      ga: begin
        wb_we_d    = 1'b1;
        wb_waddr_d = a_waddr_i;
        wb_wdata_d = a_wdata_i;
      end
      gb: begin
        wb_we_d    = 1'b1;
        wb_waddr_d = b_waddr_i;
        wb_wdata_d = b_wdata_i;
      end
      default: ;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= SIDE_B;
      cnt_q      <= '0;
      pend_q     <= '0;
      wb_we_q    <= 1'b0;
      wb_waddr_q <= '0;
      wb_wdata_q <= '0;
    end else begin
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      wb_we_q    <= wb_we_d;
      wb_waddr_q <= wb_waddr_d;
      wb_wdata_q <= wb_wdata_d;
    end
  end

  assign wb_we_o    = wb_we_q;
  assign wb_waddr_o = wb_waddr_q;
  assign wb_wdata_o = wb_wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: grants, write stage,
// scoreboard hazards, outstanding limit and reset.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;
  logic        b_valid, b_ready;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;
  logic        iss_valid, iss_stall;
  logic [4:0]  iss_waddr;
  logic        re1, re2, dst_en, rd_stall;
  logic [4:0]  raddr1, raddr2, dst_addr;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid_i(a_valid), .a_ready_o(a_ready),
    .a_waddr_i(a_waddr), .a_wdata_i(a_wdata),
    .b_valid_i(b_valid), .b_ready_o(b_ready),
    .b_waddr_i(b_waddr), .b_wdata_i(b_wdata),
    .iss_valid_i(iss_valid), .iss_waddr_i(iss_waddr),
    .iss_stall_o(iss_stall),
    .re1_i(re1), .raddr1_i(raddr1),
    .re2_i(re2), .raddr2_i(raddr2),
    .dst_en_i(dst_en), .dst_addr_i(dst_addr),
    .rd_stall_o(rd_stall),
    .wb_we_o(wb_we), .wb_waddr_o(wb_waddr), .wb_wdata_o(wb_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 0; a_waddr = 0; a_wdata = 0;
    b_valid = 0; b_waddr = 0; b_wdata = 0;
    iss_valid = 0; iss_waddr = 0;
    re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
    dst_en = 0; dst_addr = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
    #1;
  endtask

  task automatic issue(input logic [4:0] r, input string tag);
    iss_valid = 1; iss_waddr = r;
    #1;
    chk(tag, iss_stall, 0);
    tick();
    iss_valid = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;

    chk("rst_we", wb_we, 0);
    chk("rst_waddr", wb_waddr, 0);
    chk("rst_wdata", wb_wdata, 0);
    chk("rst_iss_stall", iss_stall, 0);
    chk("rst_rd_stall", rd_stall, 0);

    // A alone
    a_valid = 1; a_waddr = 3; a_wdata = 32'h11;
    #1;
    chk("a_only_ready", a_ready, 1);
    chk("a_only_bready", b_ready, 0);
    tick();
    a_valid = 0;
    #1;
    chk("a_only_we", wb_we, 1);
    chk("a_only_waddr", wb_waddr, 3);
    chk("a_only_wdata", wb_wdata, 32'h11);
    tick();
    chk("idle_we", wb_we, 0);
    chk("idle_hold_addr", wb_waddr, 3);

    // Contention from reset: A,B,A,B
    do_reset();
    a_valid = 1; a_waddr = 1; a_wdata = 32'hA1;
    b_valid = 1; b_waddr = 2; b_wdata = 32'hB2;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d_a", i), a_ready, (i % 2 == 0));
      chk($sformatf("rr%0d_b", i), b_ready, (i % 2 == 1));
      tick();
      chk($sformatf("rr%0d_we", i), wb_we, 1);
      chk($sformatf("rr%0d_addr", i), wb_waddr, (i % 2 == 0) ? 1 : 2);
    end
    a_valid = 0; b_valid = 0;
    tick();
    chk("rr_end_we", wb_we, 0);
    chk("rr_hold_data", wb_wdata, 32'hB2);

    // RAW on r5
    do_reset();
    issue(5, "raw_issue");
    re1 = 1; raddr1 = 5;
    #1;
    chk("raw_stall", rd_stall, 1);
    tick();
    chk("raw_stall_hold", rd_stall, 1);
    re1 = 0; re2 = 1; raddr2 = 5;
    #1;
    chk("raw_stall_re2", rd_stall, 1);
    re2 = 0; dst_en = 1; dst_addr = 5;
    #1;
    chk("waw_dst_stall", rd_stall, 1);
    dst_en = 0; re1 = 1;
    b_valid = 1; b_waddr = 5; b_wdata = 32'h55;
    #1;
    chk("raw_b_ready", b_ready, 1);
    chk("raw_stall_at_grant", rd_stall, 1);
    tick();
    b_valid = 0;
    #1;
    chk("raw_clear", rd_stall, 0);
    chk("raw_we", wb_we, 1);
    chk("raw_waddr", wb_waddr, 5);
    chk("raw_wdata", wb_wdata, 32'h55);
    re1 = 0;

    // WAW on r7
    do_reset();
    issue(7, "waw_first");
    iss_valid = 1; iss_waddr = 7;
    #1;
    chk("waw_second_stall", iss_stall, 1);
    iss_valid = 0;

    // Outstanding limit
    do_reset();
    for (int r = 1; r <= 4; r++) issue(5'(r), $sformatf("lim_r%0d", r));
    iss_valid = 1; iss_waddr = 6;
    #1;
    chk("lim_full", iss_stall, 1);
    iss_valid = 0;
    b_valid = 1; b_waddr = 1; b_wdata = 32'h1;
    tick();
    b_valid = 0;
    // count 3: simultaneous gB(r2) and issue(r6)
    b_valid = 1; b_waddr = 2; b_wdata = 32'h2;
    iss_valid = 1; iss_waddr = 6;
    #1;
    chk("sim_b_ready", b_ready, 1);
    chk("sim_iss_ok", iss_stall, 0);
    tick();
    b_valid = 0; iss_valid = 0;
    re1 = 1; raddr1 = 2; re2 = 0;
    #1;
    chk("sim_r2_cleared", rd_stall, 0);
    raddr1 = 6;
    #1;
    chk("sim_r6_set", rd_stall, 1);
    re1 = 0;
    issue(8, "sim_fill");
    iss_valid = 1; iss_waddr = 9;
    #1;
    chk("sim_count_full", iss_stall, 1);
    iss_valid = 0;

    // Issue to r0
    do_reset();
    for (int k = 0; k < 4; k++) issue(0, $sformatf("r0_issue%0d", k));
    re1 = 1; raddr1 = 0; re2 = 1; raddr2 = 0;
    dst_en = 1; dst_addr = 0;
    #1;
    chk("r0_no_rd_stall", rd_stall, 0);
    re1 = 0; re2 = 0; dst_en = 0;
    iss_valid = 1; iss_waddr = 0;
    #1;
    chk("r0_count_full", iss_stall, 1);
    iss_valid = 0;

    // Reset with pending r9, count 2
    do_reset();
    issue(9, "rst_p9");
    issue(10, "rst_p10");
    re1 = 1; raddr1 = 9;
    #1;
    chk("pre_rst_stall", rd_stall, 1);
    a_valid = 1; a_waddr = 4; a_wdata = 32'h44;
    rst = 1;
    tick();
    rst = 0;
    a_valid = 0;
    #1;
    chk("post_rst_we", wb_we, 0);
    chk("post_rst_rd_stall", rd_stall, 0);
    re1 = 0;
    for (int r = 11; r <= 14; r++) issue(5'(r), $sformatf("post_rst_i%0d", r));
    iss_valid = 1; iss_waddr = 15;
    #1;
    chk("post_rst_count", iss_stall, 1);
    iss_valid = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
